// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding, channel constants and counter sizing for the mux scanner.
package mux_scan_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    localparam int NUM_CH = 4;
    localparam int SEL_W = 2;
    function automatic int cnt_w(input int dwell);
        return $clog2(dwell + 1);
    endfunction
endpackage

// File: rtl/mux_4to1.sv
// mux_4to1: combinational 4-to-1 selector scanned by mux_scan_ctrl.
module mux_4to1 (
    input  logic [3:0] D,
    input  logic [1:0] Sel,
    output logic       Y
);
    assign Y = D[Sel];
endmodule

// File: rtl/mux_scan_dwell_cnt.sv
// mux_scan_dwell_cnt: dwell timer; tc marks the last cycle of each DWELL-cycle window.
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int W = cnt_w(DWELL);
    logic [W-1:0] cnt;
    assign tc = (cnt == W'(DWELL - 1));
    always_ff @(posedge clk) begin
        if (rst || clear || (en && tc))
            cnt <= '0;
        else if (en)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans a 4-to-1 mux over all channels and delivers the samples as a 4-bit valid/ready word.
// Optional macro MUX_SCAN_CONT_EN: rescan continuously after the first start instead of returning to IDLE.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [SEL_W-1:0]  Sel,
    input  logic              Y,
    output logic              busy,
    output logic [NUM_CH-1:0] word,
    output logic              word_valid,
    input  logic              word_ready
);
`ifdef MUX_SCAN_CONT_EN
    localparam logic CONT = 1'b1;
`else
    localparam logic CONT = 1'b0;
`endif
    state_t state, state_n;
    logic [NUM_CH-1:0] shadow, shadow_n;
    logic tc, last_ch, done;
    mux_scan_dwell_cnt #(.DWELL(DWELL)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clear(state != SCAN),
        .en(state == SCAN),
        .tc(tc)
    );
    assign last_ch = (Sel == SEL_W'(NUM_CH - 1));
    assign done = (state == HOLD) && word_ready;
    // Y follows Sel combinationally, so the final word takes channel 3 straight from Y.
    always_comb begin
        shadow_n = shadow;
        shadow_n[Sel] = Y;
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && start)
            state_n = SCAN;
        else if (state == SCAN && tc && last_ch)
            state_n = HOLD;
        else if (done)
            state_n = CONT ? SCAN : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            Sel        <= '0;
            busy       <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            shadow     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                Sel  <= '0;
                busy <= 1'b1;
            end
            if (state == SCAN && tc) begin
                shadow <= shadow_n;
                if (last_ch) begin
                    word       <= shadow_n;
                    word_valid <= 1'b1;
                end else begin
                    Sel <= Sel + SEL_W'(1);
                end
            end
            if (done) begin
                word_valid <= 1'b0;
                Sel        <= '0;
                busy       <= CONT;
            end
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed scenarios for mux_scan_ctrl driving a real mux_4to1, DWELL=2.
module tb_mux_scan_ctrl;
    logic clk = 0, rst = 0, start = 0, word_ready = 0;
    logic [3:0] D = 0;
    logic [1:0] Sel;
    logic Y, busy, word_valid;
    logic [3:0] word;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mux_4to1 u_mux (.D(D), .Sel(Sel), .Y(Y));
    mux_scan_ctrl #(.DWELL(2)) dut (
        .clk(clk), .rst(rst), .start(start), .Sel(Sel), .Y(Y), .busy(busy),
        .word(word), .word_valid(word_valid), .word_ready(word_ready)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step(2);
        rst = 0;
        checks++; if (Sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", Sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (word !== 4'd0) begin errors++; $display("FAIL reset_word got %b exp 0000", word); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", word_valid); end
    endtask

    task automatic test_basic();
        D = 4'b1101;
        word_ready = 1;
        pulse_start();
        checks++; if (busy !== 1'b1 || Sel !== 2'd0) begin errors++; $display("FAIL basic_accept got busy=%b sel=%0d exp busy=1 sel=0", busy, Sel); end
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 3 || k == 5 || k == 7) begin
                checks++; if (Sel !== 2'(k / 2)) begin errors++; $display("FAIL basic_sel_k%0d got %0d exp %0d", k, Sel, k / 2); end
            end
            checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid_k%0d got %b exp 0", k, word_valid); end
        end
        step();
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", word_valid); end
        checks++; if (word !== 4'b1101) begin errors++; $display("FAIL basic_word got %b exp 1101", word); end
        step();
        checks++; if (word_valid !== 1'b0 || busy !== 1'b0 || Sel !== 2'd0) begin errors++; $display("FAIL basic_after_hs got valid=%b busy=%b sel=%0d exp 0 0 0", word_valid, busy, Sel); end
        checks++; if (word !== 4'b1101) begin errors++; $display("FAIL basic_word_hold got %b exp 1101", word); end
    endtask

    task automatic test_change();
        D = 4'b0001;
        word_ready = 1;
        pulse_start();
        step(2);
        D = 4'b1000;
        step(6);
        checks++; if (word_valid !== 1'b1 || word !== 4'b1001) begin errors++; $display("FAIL change_word got valid=%b word=%b exp valid=1 word=1001", word_valid, word); end
        step();
    endtask

    task automatic test_hold();
        D = 4'b0110;
        word_ready = 0;
        pulse_start();
        step(8);
        checks++; if (word_valid !== 1'b1 || word !== 4'b0110) begin errors++; $display("FAIL hold_first got valid=%b word=%b exp 1 0110", word_valid, word); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (word_valid !== 1'b1 || word !== 4'b0110 || Sel !== 2'd3 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall_%0d got valid=%b word=%b sel=%0d busy=%b exp 1 0110 3 1", k, word_valid, word, Sel, busy);
            end
        end
        word_ready = 1;
        step();
        checks++; if (word_valid !== 1'b0 || busy !== 1'b0 || Sel !== 2'd0) begin errors++; $display("FAIL hold_release got valid=%b busy=%b sel=%0d exp 0 0 0", word_valid, busy, Sel); end
        step();
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL hold_single got %b exp 0", word_valid); end
        word_ready = 0;
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        D = 4'b1010;
        word_ready = 0;
        pulse_start();
        step(3);
        pulse_start();
        step(4);
        checks++; if (word_valid !== 1'b1 || word !== 4'b1010) begin errors++; $display("FAIL ign_word got valid=%b word=%b exp 1 1010", word_valid, word); end
        start = 1;
        word_ready = 1;
        step();
        start = 0;
        word_ready = 0;
        checks++; if (word_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ign_hs got valid=%b busy=%b exp 0 0", word_valid, busy); end
        for (int k = 0; k < 12; k++) begin
            step();
            if (word_valid !== 1'b0 || busy !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ign_requeue got %0d busy/valid cycles exp 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        D = 4'b1111;
        word_ready = 1;
        pulse_start();
        step(3);
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (Sel !== 2'd0 || busy !== 1'b0 || word !== 4'd0 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got sel=%0d busy=%b word=%b valid=%b exp 0 0 0000 0", Sel, busy, word, word_valid);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            if (word_valid !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_word got %0d valid cycles exp 0", seen); end
    endtask

    task automatic test_continuous();
        D = 4'b0110;
        word_ready = 1;
        pulse_start();
        step(8);
        for (int n = 0; n < 3; n++) begin
            checks++; if (word_valid !== 1'b1 || word !== 4'b0110) begin errors++; $display("FAIL cont_word_%0d got valid=%b word=%b exp 1 0110", n, word_valid, word); end
            step();
            checks++; if (word_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cont_gap_%0d got valid=%b busy=%b exp 0 1", n, word_valid, busy); end
            step(7);
            checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL cont_early_%0d got %b exp 0", n, word_valid); end
            step();
        end
    endtask

    initial begin
        test_reset();
`ifdef MUX_SCAN_CONT_EN
        test_continuous();
`else
        test_basic();
        test_change();
        test_hold();
        test_start_ignored();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
